// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the select (A) and enable (E) of a 4-to-16 decoder.
// Define SCAN_BLANK_EN to insert one E=0 blanking cycle on every channel change.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  mask,
  output logic [3:0]         A,
  output logic               E,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
`ifdef SCAN_BLANK_EN
    ,
    BLANK = 2'd3
`endif
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         a_reg, a_next;
  logic               e_reg, e_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               wrap_reg, wrap_next;
  logic               mode_reg, mode_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;

  logic [NUM_CH-1:0]  above_vec;
  logic [3:0]         lowest_ch;
  logic [3:0]         above_ch;
  logic               above_found;
  logic               mask_empty;
  logic [DWELL_W-1:0] dwell_m1;

  // Candidate channels strictly above the current select.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
      assign above_vec[gi] = mask[gi] && (4'(gi) > a_reg);
    end
  endgenerate

  // Descending loops leave the lowest matching index in the result.
  always_comb begin
    lowest_ch   = '0;
    above_ch    = '0;
    above_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_ch = 4'(i);
      end
      if (above_vec[i]) begin
        above_ch    = 4'(i);
        above_found = 1'b1;
      end
    end
  end

  assign mask_empty = (mask == '0);
  // The counter holds remaining cycles minus one, so dwell of 0 or 1 both give one cycle.
  assign dwell_m1   = (dwell == '0) ? '0 : dwell - 1'b1;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    e_next     = e_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;

    if (stop) begin
      state_next = IDLE;
      e_next     = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          e_next    = 1'b0;
          busy_next = 1'b0;
          if (start && !mask_empty) begin
            state_next = DRIVE;
            a_next     = lowest_ch;
            e_next     = 1'b1;
            busy_next  = 1'b1;
            mode_next  = mode;
            cnt_next   = dwell_m1;
          end
        end
        DRIVE: begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else if (mask_empty || (!above_found && mode_reg)) begin
            state_next = DONE;
            e_next     = 1'b0;
            done_next  = 1'b1;
          end else begin
            a_next    = above_found ? above_ch : lowest_ch;
            wrap_next = !above_found;
            cnt_next  = dwell_m1;
`ifdef SCAN_BLANK_EN
            state_next = BLANK;
            e_next     = 1'b0;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          state_next = DRIVE;
          e_next     = 1'b1;
        end
`endif
        DONE: begin
          state_next = IDLE;
          e_next     = 1'b0;
          busy_next  = 1'b0;
        end
        default: begin
          state_next = IDLE;
          e_next     = 1'b0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      e_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      mode_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      e_reg     <= e_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wrap_reg  <= wrap_next;
      mode_reg  <= mode_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign A    = a_reg;
  assign E    = e_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer: a scan-level model queues the
// expected per-cycle outputs of every busy cycle; a monitor pops and compares.
module tb_decoder_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  dwell = '0;
  logic [15:0] mask = '0;
  logic [3:0]  A;
  logic        E, busy, done, wrap;

  typedef struct packed {
    logic [3:0] a;
    logic       e;
    logic       done;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t seq_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   finish_req = 1'b0;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_MODEL = 1'b1;
`else
  localparam bit BLANK_MODEL = 1'b0;
`endif

  decoder_scan_sequencer #(.DWELL_W(8), .NUM_CH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .dwell(dwell), .mask(mask), .A(A), .E(E), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL leftover_expected got=%0d entries required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (!rst_n) begin
        checks++;
        if (A != 4'd0 || E || busy || done || wrap) begin
          errors++;
          $display("FAIL reset_values got A=%0d E=%0b busy=%0b done=%0b wrap=%0b required all 0",
                   A, E, busy, done, wrap);
        end
      end else if (busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy got A=%0d E=%0b done=%0b wrap=%0b required busy=0",
                   A, E, done, wrap);
        end else begin
          ex = exp_q.pop_front();
          if ({A, E, done, wrap} != ex) begin
            errors++;
            $display("FAIL scan_cycle got A=%0d E=%0b done=%0b wrap=%0b required A=%0d E=%0b done=%0b wrap=%0b",
                     A, E, done, wrap, ex.a, ex.e, ex.done, ex.wrap);
          end
        end
      end else begin
        checks++;
        if (E || done || wrap) begin
          errors++;
          $display("FAIL idle_outputs got E=%0b done=%0b wrap=%0b required all 0", E, done, wrap);
        end
      end
    end
  end

  // Scan-level reference: visit set bits in ascending order, each for max(dwell,1)
  // enabled cycles, optionally preceded by a blank cycle on every channel change.
  task automatic gen_seq(input logic [15:0] m, input int d, input bit md, input int limit);
    int  de;
    int  chans[$];
    bit  first;
    int  pass;
    bit  wr;
    de    = (d == 0) ? 1 : d;
    first = 1'b1;
    pass  = 0;
    seq_q.delete();
    for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
    if (chans.size() == 0) return;
    while (seq_q.size() < limit) begin
      for (int k = 0; k < chans.size(); k++) begin
        wr = (pass > 0) && (k == 0);
        if (!first && BLANK_MODEL) seq_q.push_back('{a: 4'(chans[k]), e: 1'b0, done: 1'b0, wrap: wr});
        for (int c = 0; c < de; c++)
          seq_q.push_back('{a: 4'(chans[k]), e: 1'b1, done: 1'b0,
                            wrap: (!BLANK_MODEL && wr && c == 0)});
        first = 1'b0;
      end
      if (md) begin
        seq_q.push_back('{a: 4'(chans[chans.size()-1]), e: 1'b0, done: 1'b1, wrap: 1'b0});
        break;
      end
      pass++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy || exp_q.size() != 0) begin
      start = busy && ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (n > 3000) begin
        $display("FAIL timeout_%s got busy=%0b pending=%0d required idle", tag, busy, exp_q.size());
        $fatal(1);
      end
    end
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] m, input int d, input bit md, input int j, input bit stop_with_start);
    mask  = m;
    dwell = 8'(d);
    mode  = md;
    if (m != 16'h0) begin
      gen_seq(m, d, md, md ? 100000 : j);
      for (int k = 0; k < seq_q.size() && (md || k < j); k++) exp_q.push_back(seq_q[k]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (m == 16'h0) begin
      repeat (3) tick();
    end else if (!md) begin
      for (int k = 1; k < j; k++) tick();
      stop  = 1'b1;
      start = stop_with_start;
      tick();
      stop  = 1'b0;
      start = 1'b0;
    end
    wait_idle("scan");
  endtask

  initial begin : driver
    int guard;
    logic [15:0] m;
    repeat (3) tick();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) tick();

    run_scan(16'h0094, 3, 1'b1, 0, 1'b0);
    run_scan(16'h8001, 0, 1'b0, 9, 1'b0);
    run_scan(16'h00F0, 2, 1'b0, 5, 1'b1);
    run_scan(16'h0000, 2, 1'b0, 0, 1'b0);
    run_scan(16'h0003, 2, 1'b0, 12, 1'b0);
    run_scan(16'h0400, 2, 1'b0, 7, 1'b0);

    // Live mask: clearing the mask on channel 9 ends the scan exactly like a
    // single pass over channels 0..9 would.
    mask  = 16'hFFFF;
    dwell = 8'd3;
    mode  = 1'b0;
    gen_seq(16'h03FF, 3, 1'b1, 100000);
    foreach (seq_q[k]) exp_q.push_back(seq_q[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(A == 4'd9 && E) && guard < 300) begin tick(); guard++; end
    mask = 16'h0000;
    wait_idle("live_mask");

    // Asynchronous reset mid-scan while A=5.
    mask  = 16'h0020;
    dwell = 8'd3;
    mode  = 1'b0;
    gen_seq(16'h0020, 3, 1'b0, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(seq_q[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) tick();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) tick();

    for (int t = 0; t < 40; t++) begin
      m = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) m = 16'h0;
      run_scan(m, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    finish_req = 1'b1;
    forever tick();
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 4-to-16 decoder: generates the 4-bit select A and the enable E.
- Steps through the 16 decoder outputs in ascending order, skipping masked channels.
- Holds each channel for a programmable dwell time; used for LED/display row multiplexing and channel polling.
- Supports continuous scan or single pass, with start/stop control and status pulses.

Parameters:
DWELL_W, 8, width of dwell input and internal dwell counter
NUM_CH, 16, channel count; fixed at 16 (A is 4 bits), not for override

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle start request
stop  input  1  one-cycle abort request
mode  input  1  0 = continuous scan, 1 = single pass; sampled on accepted start
dwell  input  DWELL_W  cycles E is high per channel; 0 treated as 1; sampled on each channel entry
mask  input  16  bit i = 1 means visit channel i; read live at each channel selection
A  output  4  decoder select, registered
E  output  1  decoder enable, registered, active-high
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse at end of a single pass or on a mask-empty abort
wrap  output  1  one-cycle pulse when a continuous scan wraps to the lowest channel

Behaviour:
- Reset (async assert, sync release): state IDLE; A=0, E=0, busy=0, done=0, wrap=0; dwell counter=0; mode register=0.
- All outputs are registered. Next-channel search is combinational: the next set mask bit strictly above the current A, or the lowest set bit on wrap.
- States: IDLE, DRIVE, DONE. BLANK exists only under the optional macro.
- IDLE:
  - E=0; A holds its last value.
  - start=1, stop=0, mask!=0 -> next cycle DRIVE, A=lowest set mask bit, E=1, busy=1, mode latched.
  - start with mask==0 -> stay IDLE, no pulse.
- DRIVE:
  - E=1 for exactly max(dwell,1) cycles per channel.
  - On the last dwell cycle, select the next channel:
    - A set bit exists above A -> A=that bit; E stays 1.
    - No bit above A, mode=0, mask!=0 -> A=lowest set bit; wrap=1 for one cycle.
    - No bit above A, mode=1 -> DONE.
    - mask==0 at the selection point -> DONE.
- DONE: one cycle with E=0, done=1, busy=1; then IDLE with busy=0.
- stop=1 in any state -> next cycle IDLE, E=0, busy=0, no done pulse. stop wins over a simultaneous start.
- start while busy: ignored.
- A single-bit mask in continuous mode keeps A constant, keeps E=1, and pulses wrap every dwell period.
- Latency: start edge to first E=1 is 1 cycle.
- Reset asserted mid-scan: outputs go to reset values immediately, asynchronously.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - Every channel change, including wrap, inserts one BLANK cycle: A updates to the new channel and E=0; E returns to 1 on the following cycle.
  - The wrap pulse coincides with the BLANK cycle.
  - Purpose: prevents ghosting on muxed displays.
  - Per-channel period = dwell+1 cycles.
- Undefined:
  - BLANK state absent; A switches while E stays 1.
  - Per-channel period = dwell cycles.

Test Plan:
- Reset/idle: assert rst_n=0 mid-DRIVE with A=5 -> A=0, E=0, busy=0 immediately; after release, outputs stay idle without start.
- Single pass: mask=16'h0094, dwell=3, mode=1, start -> A=2,4,7, each with E high for 3 cycles; then one DONE cycle with done=1, E=0; then busy=0. Total 10 cycles from start.
- Continuous wrap: mask=16'h8001, dwell=0 (treated as 1), mode=0 -> A alternates 0,15,0,15; wrap pulses on each 15->0 transition; E constant 1 (macro off).
- Stop priority: during DRIVE, pulse start and stop together -> next cycle IDLE, E=0, no done. Then start with mask=0 -> remains IDLE.
- Live mask: continuous scan on mask=16'hFFFF, clear mask to 0 while A=9 -> on dwell expiry DONE with done=1, then IDLE.
- SCAN_BLANK_EN: mask=16'h0003, dwell=2 -> E pattern 1,1,0,1,1,0 with A=0,0,1,1,1,0; wrap on the blank cycle where A returns to 0.
